// File: rtl/ctrl_pipe_decoder.sv
// ID-stage decoder feeding a registered ID/EX control bundle with valid/ready handshake,
// load-use stall, flush and illegal flag. Define CTRL_MUL_EN to enable multi-cycle mul.
module ctrl_pipe_decoder #(
  parameter int ALUOP_W    = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [31:0]        id_instr,
  input  logic               flush,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [1:0]         ex_pc_src,
  output logic               ex_reg_wr,
  output logic               ex_mem_rd,
  output logic               ex_mem_wr,
  output logic               ex_alu_src1,
  output logic               ex_alu_src2,
  output logic               ex_ext_op,
  output logic               ex_lu_op,
  output logic [1:0]         ex_reg_dst,
  output logic [1:0]         ex_mem_to_reg,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [4:0]         ex_rd_addr,
  output logic               ex_busy,
  output logic               ex_illegal
);

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_MUL    = 6'h1c;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_MUL    = 6'h02;

  typedef struct packed {
    logic [1:0]         pc_src;
    logic               reg_wr;
    logic               mem_rd;
    logic               mem_wr;
    logic               alu_src1;
    logic               alu_src2;
    logic               ext_op;
    logic               lu_op;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic [4:0]         rd_addr;
    logic               illegal;
  } ctrl_t;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = id_instr[31:26];
  assign rs     = id_instr[25:21];
  assign rt     = id_instr[20:16];
  assign rd     = id_instr[15:11];
  assign funct  = id_instr[5:0];

  logic unused_shamt;
  assign unused_shamt = ^id_instr[10:6];

  logic is_rtype;
  logic is_shift;
  logic is_jr;
  logic is_jalr;
  logic is_jump;
  logic is_lw;
  logic is_sw;
  logic is_lui;
  logic is_andi;
  logic is_mul;
  logic fn_known;
  logic op_known;
  logic legal;
  logic no_wr;

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_shift = is_rtype & ((funct == FN_SLL) | (funct == FN_SRL) | (funct == FN_SRA));
  assign is_jr    = is_rtype & (funct == FN_JR);
  assign is_jalr  = is_rtype & (funct == FN_JALR);
  assign is_jump  = (opcode == OP_J) | (opcode == OP_JAL);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_lui   = (opcode == OP_LUI);
  assign is_andi  = (opcode == OP_ANDI);

`ifdef CTRL_MUL_EN
  assign is_mul = (opcode == OP_MUL) & (funct == FN_MUL);
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    fn_known = 1'b0;
    case (funct)
      FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_JALR,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2a, 6'h2b: fn_known = 1'b1;
      default:      fn_known = 1'b0;
    endcase
  end

  always_comb begin
    op_known = 1'b0;
    case (opcode)
      6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
      OP_LW, OP_SW: op_known = 1'b1;
      default:      op_known = 1'b0;
    endcase
  end

  assign legal = (is_rtype & fn_known) | op_known | is_mul;
  // Instructions that never write the register file: stores, branches, plain jumps.
  assign no_wr = is_sw | (opcode == OP_REGIMM) | (opcode == OP_J) |
                 (opcode[5:2] == 4'b0001) | is_jr;

  ctrl_t dec;

  always_comb begin
    dec            = '0;
    dec.illegal    = ~legal;
    dec.reg_wr     = legal & ~no_wr;
    dec.mem_rd     = legal & is_lw;
    dec.mem_wr     = legal & is_sw;
    dec.alu_src1   = is_shift;
    dec.alu_src2   = ~(is_rtype | is_mul);
    dec.ext_op     = ~(is_lui | is_andi);
    dec.lu_op      = is_lui;
    if (is_jump)
      dec.pc_src = 2'b01;
    else if (is_jr | is_jalr)
      dec.pc_src = 2'b10;
    if (is_rtype | is_mul)
      dec.reg_dst = 2'b01;
    else if (opcode == OP_JAL)
      dec.reg_dst = 2'b10;
    if (is_lw)
      dec.mem_to_reg = 2'b01;
    else if ((opcode == OP_JAL) | is_jalr)
      dec.mem_to_reg = 2'b10;
    if (is_rtype)
      dec.alu_op[2:0] = 3'b010;
    else if (is_andi)
      dec.alu_op[2:0] = 3'b100;
    else if (is_mul)
      dec.alu_op[2:0] = 3'b110;
    else if ((opcode == OP_SLTI) | (opcode == OP_SLTIU))
      dec.alu_op[2:0] = 3'b101;
    dec.alu_op[3] = opcode[0];
    case (dec.reg_dst)
      2'b01:   dec.rd_addr = rd;
      2'b10:   dec.rd_addr = 5'd31;
      default: dec.rd_addr = rt;
    endcase
  end

  ctrl_t bundle_q;
  ctrl_t bundle_d;
  logic  valid_q;
  logic  valid_d;
  logic  adv;
  logic  accept;
  logic  load_use;
  logic  rs_used;
  logic  rt_used;

  assign rs_used = ~(is_jump | is_lui | is_shift);
  assign rt_used = is_rtype | is_mul | is_sw | (opcode == OP_BEQ) | (opcode == OP_BNE);

  // A load in EX whose destination feeds the ID instruction cannot forward in time.
  assign load_use = ex_valid & bundle_q.mem_rd & (bundle_q.rd_addr != 5'd0) &
                    ((rs_used & (rs == bundle_q.rd_addr)) |
                     (rt_used & (rt == bundle_q.rd_addr)));

  assign adv      = (~ex_valid | ex_ready) & ~ex_busy;
  assign id_ready = flush | (adv & ~load_use);
  assign accept   = adv & id_valid & ~load_use & ~flush;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d  = 1'b0;
      bundle_d = '0;
    end else if (adv) begin
      valid_d  = accept;
      bundle_d = accept ? dec : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

`ifdef CTRL_MUL_EN
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Counter holds the remaining EX occupancy of a mul; the bundle is hidden until it drains.
  always_comb begin
    cnt_d = cnt_q;
    if (flush)
      cnt_d = 4'd0;
    else if (adv)
      cnt_d = (accept & is_mul) ? MUL_LOAD : 4'd0;
    else if (cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= 4'd0;
    else
      cnt_q <= cnt_d;
  end

  assign ex_busy = (cnt_q != 4'd0);
`else
  logic unused_mul_cfg;
  assign unused_mul_cfg = (MUL_CYCLES > 0);
  assign ex_busy        = 1'b0;
`endif

  assign ex_valid      = valid_q & ~ex_busy;
  assign ex_pc_src     = bundle_q.pc_src;
  assign ex_reg_wr     = bundle_q.reg_wr;
  assign ex_mem_rd     = bundle_q.mem_rd;
  assign ex_mem_wr     = bundle_q.mem_wr;
  assign ex_alu_src1   = bundle_q.alu_src1;
  assign ex_alu_src2   = bundle_q.alu_src2;
  assign ex_ext_op     = bundle_q.ext_op;
  assign ex_lu_op      = bundle_q.lu_op;
  assign ex_reg_dst    = bundle_q.reg_dst;
  assign ex_mem_to_reg = bundle_q.mem_to_reg;
  assign ex_alu_op     = bundle_q.alu_op;
  assign ex_rd_addr    = bundle_q.rd_addr;
  assign ex_illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Randomised scoreboard bench for ctrl_pipe_decoder; expected bundles come from an
// instruction-level reference model (mul expectations follow CTRL_MUL_EN when defined).
module tb_ctrl_pipe_decoder;

   localparam int MUL_CYCLES = 4;
`ifdef CTRL_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [1:0] pcSrc;
      logic       regWr;
      logic       memRd;
      logic       memWr;
      logic       aluSrc1;
      logic       aluSrc2;
      logic       extOp;
      logic       luOp;
      logic [1:0] regDst;
      logic [1:0] memToReg;
      logic [3:0] aluOp;
      logic [4:0] rdAddr;
      logic       illegal;
   } bundle_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        idValid;
   logic        idReady;
   logic [31:0] idInstr;
   logic        flush;
   logic        exValid;
   logic        exReady;
   logic [1:0]  exPcSrc;
   logic        exRegWr;
   logic        exMemRd;
   logic        exMemWr;
   logic        exAluSrc1;
   logic        exAluSrc2;
   logic        exExtOp;
   logic        exLuOp;
   logic [1:0]  exRegDst;
   logic [1:0]  exMemToReg;
   logic [3:0]  exAluOp;
   logic [4:0]  exRdAddr;
   logic        exBusy;
   logic        exIllegal;

   bundle_t     dutBundle;

   int          vectors = 0;
   int          miscompares = 0;

   // Reference state: what the EX register holds and how many busy cycles remain.
   bit          mOcc;
   bundle_t     mBundle;
   int          mBusy;
   bundle_t     expQ[$];

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   ctrl_pipe_decoder #(.ALUOP_W(4), .MUL_CYCLES(MUL_CYCLES)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (idValid),
      .id_ready     (idReady),
      .id_instr     (idInstr),
      .flush        (flush),
      .ex_valid     (exValid),
      .ex_ready     (exReady),
      .ex_pc_src    (exPcSrc),
      .ex_reg_wr    (exRegWr),
      .ex_mem_rd    (exMemRd),
      .ex_mem_wr    (exMemWr),
      .ex_alu_src1  (exAluSrc1),
      .ex_alu_src2  (exAluSrc2),
      .ex_ext_op    (exExtOp),
      .ex_lu_op     (exLuOp),
      .ex_reg_dst   (exRegDst),
      .ex_mem_to_reg(exMemToReg),
      .ex_alu_op    (exAluOp),
      .ex_rd_addr   (exRdAddr),
      .ex_busy      (exBusy),
      .ex_illegal   (exIllegal)
   );

   assign dutBundle = {exPcSrc, exRegWr, exMemRd, exMemWr, exAluSrc1, exAluSrc2, exExtOp,
                       exLuOp, exRegDst, exMemToReg, exAluOp, exRdAddr, exIllegal};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit isMul(input logic [31:0] ins);
      return MUL_EN && ins[31:26] == 6'h1c && ins[5:0] == 6'h02;
   endfunction

   function automatic bit isRtype(input logic [31:0] ins);
      return ins[31:26] == 6'h00;
   endfunction

   function automatic bit isShift(input logic [31:0] ins);
      return isRtype(ins) && (ins[5:0] inside {6'h00, 6'h02, 6'h03});
   endfunction

   function automatic bit rsUsed(input logic [31:0] ins);
      return !((ins[31:26] inside {6'h02, 6'h03, 6'h0f}) || isShift(ins));
   endfunction

   function automatic bit rtUsed(input logic [31:0] ins);
      return isRtype(ins) || isMul(ins) || (ins[31:26] inside {6'h2b, 6'h04, 6'h05});
   endfunction

   // Instruction-level decode table written from the instruction classes, not the RTL.
   function automatic bundle_t decode(input logic [31:0] ins);
      bundle_t    b;
      logic [5:0] op;
      logic [5:0] fn;
      bit         rt;
      bit         legal;
      op    = ins[31:26];
      fn    = ins[5:0];
      rt    = isRtype(ins);
      legal = (rt && (fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2a, 6'h2b}))
              || (op inside {[6'h01:6'h0f], 6'h23, 6'h2b}) || isMul(ins);
      b          = '0;
      b.illegal  = !legal;
      b.pcSrc    = (op inside {6'h02, 6'h03}) ? 2'd1 : (rt && (fn inside {6'h08, 6'h09})) ? 2'd2 : 2'd0;
      b.regWr    = legal && !((op inside {6'h2b, 6'h01, 6'h02, [6'h04:6'h07]}) || (rt && fn == 6'h08));
      b.memRd    = legal && op == 6'h23;
      b.memWr    = legal && op == 6'h2b;
      b.aluSrc1  = isShift(ins);
      b.aluSrc2  = !(rt || isMul(ins));
      b.extOp    = !(op inside {6'h0f, 6'h0c});
      b.luOp     = op == 6'h0f;
      b.regDst   = (rt || isMul(ins)) ? 2'd1 : (op == 6'h03) ? 2'd2 : 2'd0;
      b.memToReg = (op == 6'h23) ? 2'd1 : ((op == 6'h03) || (rt && fn == 6'h09)) ? 2'd2 : 2'd0;
      b.aluOp[2:0] = rt ? 3'd2 : (op == 6'h0c) ? 3'd4 : isMul(ins) ? 3'd6 :
                     (op inside {6'h0a, 6'h0b}) ? 3'd5 : 3'd0;
      b.aluOp[3] = op[0];
      b.rdAddr   = (b.regDst == 2'd1) ? ins[15:11] : (b.regDst == 2'd2) ? 5'd31 : ins[20:16];
      return b;
   endfunction

   function automatic logic [31:0] randInstr();
      int          sel;
      int          fsel;
      logic [31:0] r;
      logic [5:0]  op;
      logic [5:0]  fn;
      r    = $urandom();
      sel  = $urandom_range(0, 23);
      fsel = $urandom_range(0, 15);
      if (sel <= 5)       op = 6'h00;
      else if (sel <= 8)  op = 6'h23;
      else if (sel == 9)  op = 6'h2b;
      else if (sel == 10) op = 6'h1c;
      else if (sel == 11) op = 6'h3f;
      else if (sel == 12) op = r[31:26];
      else                op = 6'(sel - 12);
      if (fsel <= 4)       fn = (fsel == 0) ? 6'h00 : (fsel == 1) ? 6'h02 : (fsel == 2) ? 6'h03 :
                                (fsel == 3) ? 6'h08 : 6'h09;
      else if (fsel <= 12) fn = 6'(32'h20 + fsel - 5);
      else if (fsel == 13) fn = 6'h2a;
      else if (fsel == 14) fn = 6'h2b;
      else                 fn = r[5:0];
      if (op == 6'h1c && r[6]) fn = 6'h02;
      return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), r[10:6], fn};
   endfunction

   // One cycle: drive inputs, check against the model, then advance the model at the edge.
   task automatic applyStimulus(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
      bit busyM;
      bit validM;
      bit advM;
      bit hazard;
      bit readyM;
      idValid = v;
      idInstr = ins;
      exReady = rdy;
      flush   = fl;
      #2;
      busyM  = mBusy > 0;
      validM = mOcc && !busyM;
      advM   = (!validM || rdy) && !busyM;
      hazard = validM && mBundle.memRd && mBundle.rdAddr != 5'd0 &&
               ((rsUsed(ins) && ins[25:21] == mBundle.rdAddr) ||
                (rtUsed(ins) && ins[20:16] == mBundle.rdAddr));
      readyM = fl || (advM && !hazard);
      checkOutput("id_ready", 32'(idReady), 32'(readyM));
      checkOutput("ex_valid", 32'(exValid), 32'(validM));
      checkOutput("ex_busy", 32'(exBusy), 32'(busyM));
      checkOutput("held_bundle", 32'(dutBundle), mOcc ? 32'(mBundle) : 32'd0);
      @(posedge clk);
      if (fl) begin
         if (mOcc && expQ.size() > 0) void'(expQ.pop_front());
         mOcc  = 1'b0;
         mBusy = 0;
      end else if (advM) begin
         if (v && !hazard) begin
            mBundle = decode(ins);
            mOcc    = 1'b1;
            mBusy   = isMul(ins) ? MUL_CYCLES - 1 : 0;
            expQ.push_back(mBundle);
         end else begin
            mOcc = 1'b0;
         end
      end else if (mBusy > 0) begin
         mBusy--;
      end
      #2;
   endtask

   // Asynchronous reset between edges; outputs must clear before the next clock.
   task automatic pulseReset();
      idValid = 1'b0;
      flush   = 1'b0;
      exReady = 1'b0;
      #1 reset = 1'b1;
      #1;
      checkOutput("reset_ex_valid", 32'(exValid), 32'd0);
      checkOutput("reset_ex_busy", 32'(exBusy), 32'd0);
      checkOutput("reset_bundle", 32'(dutBundle), 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      mOcc  = 1'b0;
      mBusy = 0;
      expQ.delete();
   endtask

   // Monitor: whenever EX consumes a bundle, it must be the oldest expected one.
   always @(negedge clk) begin
      if (!reset && exValid && exReady && !flush) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_ex_valid", 32'(exValid), 32'd0);
         end else begin
            checkOutput("ex_bundle", 32'(dutBundle), 32'(expQ.pop_front()));
         end
      end
   end

   // Watchdog so a broken design can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios first, then a long randomised stream.
   initial begin
      reset   = 1'b1;
      idValid = 1'b0;
      idInstr = 32'd0;
      flush   = 1'b0;
      exReady = 1'b0;
      mOcc    = 1'b0;
      mBusy   = 0;
      mBundle = '0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("init_ex_valid", 32'(exValid), 32'd0);
      checkOutput("init_ex_busy", 32'(exBusy), 32'd0);
      checkOutput("init_bundle", 32'(dutBundle), 32'd0);
      reset = 1'b0;

      applyStimulus(1'b1, 32'h00221820, 1'b1, 1'b0);
      checkOutput("add_ex_valid", 32'(exValid), 32'd1);
      checkOutput("add_reg_wr", 32'(exRegWr), 32'd1);
      checkOutput("add_reg_dst", 32'(exRegDst), 32'd1);
      checkOutput("add_alu_op", 32'(exAluOp), 32'd2);
      checkOutput("add_rd_addr", 32'(exRdAddr), 32'd3);

      applyStimulus(1'b1, 32'h8C250000, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h00A23020, 1'b1, 1'b0);
      checkOutput("load_use_bubble", 32'(exValid), 32'd0);
      applyStimulus(1'b1, 32'h00A23020, 1'b1, 1'b0);
      checkOutput("load_use_issue_rd", 32'(exRdAddr), 32'd6);

      applyStimulus(1'b1, 32'h70432002, 1'b1, 1'b0);
      repeat (5) applyStimulus(1'b1, 32'h00221820, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h70432002, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h00221820, 1'b1, 1'b1);
      checkOutput("flush_ex_busy", 32'(exBusy), 32'd0);
      checkOutput("flush_ex_valid", 32'(exValid), 32'd0);
      applyStimulus(1'b1, 32'h00221820, 1'b1, 1'b0);

      applyStimulus(1'b1, 32'h00221820, 1'b1, 1'b0);
      repeat (5) applyStimulus(1'b1, 32'h00432020, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00432020, 1'b1, 1'b0);

      applyStimulus(1'b1, 32'hFC221820, 1'b1, 1'b0);
      checkOutput("illegal_flag", 32'(exIllegal), 32'd1);
      checkOutput("illegal_reg_wr", 32'(exRegWr), 32'd0);
      checkOutput("illegal_mem_wr", 32'(exMemWr), 32'd0);
      applyStimulus(1'b1, 32'h70432002, 1'b0, 1'b0);
      pulseReset();

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) pulseReset();
         applyStimulus($urandom_range(0, 9) < 8, randInstr(),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      end

      repeat (8) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
